pipo_pipe: RTL and testbench

//  Parametrised elastic pipeline of DEPTH parallel-in/parallel-out register stages with valid/ready

---
 rtl/mdr_pkg.sv | 6 +
 rtl/pipo_stage.sv | 35 +++
 rtl/pipo_pipe.sv | 110 +++++++++++
 tb/tb_pipo_pipe.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared definitions for the multiply/divide/root datapath: operand widths and pipe defaults.
package mdr_pkg;
  localparam int DW_DBL         = 64;
  localparam int PIPE_DEPTH_DEF = 2;
  typedef logic [DW_DBL:0] dbl_word_t;
endpackage

// File: rtl/pipo_stage.sv
// One {valid,data} register of the elastic pipe: async reset, sync clear, load on advance.
module pipo_stage
  import mdr_pkg::*;
#(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          ld_i,
  input  logic          vld_i,
  input  logic [SW-1:0] data_i,
  output logic          vld_o,
  output logic [SW-1:0] data_o
);
  logic          vld_q;
  logic [SW-1:0] data_q;

  // A bubble moving in clears valid but leaves the old data in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (clr_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (ld_i) begin
      vld_q <= vld_i;
      if (vld_i) data_q <= data_i;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
endmodule

// File: rtl/pipo_pipe.sv
// Elastic DEPTH-stage valid/ready register pipe with global enable, flush and occupancy.
// Optional PIPO_PIPE_PARITY_EN adds a per-stage even-parity bit and a sticky par_err output.
module pipo_pipe
  import mdr_pkg::*;
#(
  parameter int W     = DW_DBL + 1,
  parameter int DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enb,
  input  logic                       sync_clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
`ifdef PIPO_PIPE_PARITY_EN
  output logic                       par_err,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occ
);
`ifdef PIPO_PIPE_PARITY_EN
  localparam int SW = W + 1;
`else
  localparam int SW = W;
`endif
  localparam int OW = $clog2(DEPTH+1);

  logic                     run, flush;
  logic [SW-1:0]            in_word;
  logic [DEPTH-1:0]         v, vin, adv;
  logic [DEPTH-1:0][SW-1:0] sd, din;

  assign run   = enb & ~sync_clr;
  assign flush = enb & sync_clr;

`ifdef PIPO_PIPE_PARITY_EN
  assign in_word = {^in_data, in_data};
`else
  assign in_word = in_data;
`endif

  // Ready ripples from the output back to the input in one cycle.
  always_comb begin
    logic a;
    adv = '0;
    a   = run & (~v[DEPTH-1] | out_ready);
    adv[DEPTH-1] = a;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      a      = run & (~v[i] | a);
      adv[i] = a;
    end
  end

  always_comb begin
    vin    = '0;
    din    = '0;
    vin[0] = in_valid;
    din[0] = in_word;
    for (int i = 1; i < DEPTH; i++) begin
      vin[i] = v[i-1];
      din[i] = sd[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    pipo_stage #(.SW(SW)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (flush),
      .ld_i   (adv[g]),
      .vld_i  (vin[g]),
      .data_i (din[g]),
      .vld_o  (v[g]),
      .data_o (sd[g])
    );
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + OW'(v[i]);
  end

  // Reset is async, so in_ready is gated with it directly.
  assign in_ready  = adv[0] & rst;
  assign out_valid = v[DEPTH-1];
  assign out_data  = sd[DEPTH-1][W-1:0];

`ifdef PIPO_PIPE_PARITY_EN
  logic par_last;
  logic par_err_q, par_err_d;

  assign par_last = sd[DEPTH-1][W];

  always_comb begin
    par_err_d = par_err_q;
    if (out_valid && (par_last != ^sd[DEPTH-1][W-1:0])) par_err_d = 1'b1;
    if (flush) par_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_err_q <= 1'b0;
    else      par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`endif
endmodule

// File: tb/tb_pipo_pipe.sv
// Bench for pipo_pipe (W=8, DEPTH=3): directed vector table plus randomized queue-model run.
module tb_pipo_pipe;
  localparam int W = 8, DEPTH = 3, OW = $clog2(DEPTH + 1);

  logic clk = 1'b0, rst = 1'b0, enb = 1'b0, sync_clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [OW-1:0] occ;
`ifdef PIPO_PIPE_PARITY_EN
  logic par_err;
`endif

  pipo_pipe #(.W(W), .DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .sync_clr  (sync_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PIPO_PIPE_PARITY_EN
    .par_err   (par_err),
`endif
    .occ       (occ)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic       en, clr, iv;
    logic [7:0] id;
    logic       ordy;
    logic       xr, xv;
    logic [7:0] xd;
    logic [1:0] xo;
  } vec_t;

  vec_t tbl[$];
  logic [W-1:0] q[$];

  initial begin
    // Streaming, back-pressure, flush, enable freeze; expectations are pre-edge state.
    tbl.push_back(vec_t'{1,0,1,8'h11,1, 1,0,8'h00,0});
    tbl.push_back(vec_t'{1,0,1,8'h22,1, 1,0,8'h00,1});
    tbl.push_back(vec_t'{1,0,1,8'h33,1, 1,0,8'h00,2});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,1,8'h11,3});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,1,8'h22,2});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,1,8'h33,1});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,0,8'h33,0});
    tbl.push_back(vec_t'{1,0,1,8'h01,0, 1,0,8'h33,0});
    tbl.push_back(vec_t'{1,0,1,8'h02,0, 1,0,8'h33,1});
    tbl.push_back(vec_t'{1,0,1,8'h03,0, 1,0,8'h33,2});
    tbl.push_back(vec_t'{1,0,1,8'h04,0, 0,1,8'h01,3});
    tbl.push_back(vec_t'{1,0,1,8'h04,1, 1,1,8'h01,3});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,1,8'h02,3});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,1,8'h03,2});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,1,8'h04,1});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,0,8'h04,0});
    tbl.push_back(vec_t'{1,0,1,8'h05,0, 1,0,8'h04,0});
    tbl.push_back(vec_t'{1,0,1,8'h06,0, 1,0,8'h04,1});
    tbl.push_back(vec_t'{1,1,1,8'hAA,0, 0,0,8'h04,2});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,0,8'h00,0});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,0,8'h00,0});
    tbl.push_back(vec_t'{1,0,1,8'h07,1, 1,0,8'h00,0});
    tbl.push_back(vec_t'{1,0,1,8'h08,1, 1,0,8'h00,1});
    for (int k = 0; k < 5; k++) tbl.push_back(vec_t'{0,0,1,8'h09,1, 0,0,8'h00,2});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,0,8'h00,2});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,1,8'h07,2});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,1,8'h08,1});
    tbl.push_back(vec_t'{1,0,0,8'h00,1, 1,0,8'h08,0});

    // Reset with traffic offered
    enb = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data",  32'(out_data),  0);
    chk("rst occ",       32'(occ),       0);
    chk("rst in_ready",  32'(in_ready),  0);
    in_valid = 1'b0;
    rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      enb = tbl[i].en; sync_clr = tbl[i].clr; in_valid = tbl[i].iv;
      in_data = tbl[i].id; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(tbl[i].xr));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].xv));
      chk($sformatf("v%0d out_data", i),  32'(out_data),  32'(tbl[i].xd));
      chk($sformatf("v%0d occ", i),       32'(occ),       32'(tbl[i].xo));
    end

    // Randomized run against an ordered-queue model
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; sync_clr = 1'b0;
    #2 rst = 1'b1;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic exp_rdy;
      @(negedge clk);
      enb       = ($urandom_range(0, 9) != 0);
      sync_clr  = ($urandom_range(0, 49) == 0);
      in_valid  = $urandom_range(0, 1);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = enb & ~sync_clr & (out_ready | (q.size() < DEPTH));
      chk("rnd occ", 32'(occ), 32'(q.size()));
      chk("rnd in_ready", 32'(in_ready), 32'(exp_rdy));
      if (out_valid) chk("rnd out_data", 32'(out_data), (q.size() > 0) ? 32'(q[0]) : 32'hDEAD_BEEF);
      if (enb && sync_clr) q.delete();
      else if (enb) begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && exp_rdy) q.push_back(in_data);
      end
    end

    // Drain with a bounded budget
    @(negedge clk);
    enb = 1'b1; sync_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4 * DEPTH && q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        chk("drain out_data", 32'(out_data), 32'(q[0]));
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    #1;
    chk("drain model empty", 32'(q.size()), 0);
    chk("drain occ", 32'(occ), 0);

`ifdef PIPO_PIPE_PARITY_EN
    // Corrupt the last-stage parity bit while a word sits there
    chk("par idle", 32'(par_err), 0);
    @(negedge clk); in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    repeat (DEPTH) @(negedge clk);
    force u_dut.par_last = 1'b0;
    @(negedge clk); #1;
    chk("par set", 32'(par_err), 1);
    release u_dut.par_last;
    @(negedge clk); #1;
    chk("par held", 32'(par_err), 1);
    sync_clr = 1'b1;
    @(negedge clk); sync_clr = 1'b0; #1;
    chk("par clr", 32'(par_err), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
